// File: rtl/cfu_seq_pkg.sv
// Shared definitions for the CFU MAC sequencer: opcodes, FSM states, widths.
// No ports; imported by the sequencer top and the SIMD MAC datapath.
package cfu_seq_pkg;

    localparam int LANE_W = 8;
    localparam int ACC_W  = 32;

    localparam logic [2:0] OP_WR_IN    = 3'd0;
    localparam logic [2:0] OP_WR_FILT  = 3'd1;
    localparam logic [2:0] OP_SET_OFF  = 3'd2;
    localparam logic [2:0] OP_RUN      = 3'd3;
    localparam logic [2:0] OP_RUN_CONT = 3'd4;
    localparam logic [2:0] OP_READ     = 3'd5;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        STREAM,
        RESP
    } state_e;

endpackage

// File: rtl/cfu_mac_sequencer_simd4_mac.sv
// Combinational 4-lane int8 offset-multiply-sum.
// Ports: in_word/filt_word (4 x int8 lanes), offset (s16) -> sum (s32).
module simd4_mac
    import cfu_seq_pkg::*;
(
    input  logic [31:0]      in_word,
    input  logic [31:0]      filt_word,
    input  logic [15:0]      offset,
    output logic [ACC_W-1:0] sum
);

    always_comb begin
        logic signed [16:0] s;
        logic signed [7:0]  f;
        logic signed [24:0] p;
        sum = '0;
        s   = '0;
        f   = '0;
        p   = '0;
        for (int i = 0; i < 4; i++) begin
            // 17-bit signed sum avoids overflow of int8 + int16
            s = {{9{in_word[i*LANE_W+7]}}, in_word[i*LANE_W +: LANE_W]}
              + {offset[15], offset};
            f = filt_word[i*LANE_W +: LANE_W];
            p = s * f;
            sum = sum + {{(ACC_W-25){p[24]}}, p};
        end
    end

endmodule

// File: rtl/cfu_mac_sequencer.sv
// CFU controller: buffers activation/filter words, streams N pairs through
// a SIMD MAC on RUN. Ports: CFU cmd (valid/ready/function_id/inputs) and rsp.
module cfu_mac_sequencer
    import cfu_seq_pkg::*;
#(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [9:0]  cmd_payload_function_id,
    input  logic [31:0] cmd_payload_inputs_0,
    input  logic [31:0] cmd_payload_inputs_1,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_payload_outputs_0
);

    state_e             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [ACC_W-1:0]   rsp_q, rsp_d;
    logic [15:0]        off_q, off_d;
    logic [ADDR_W-1:0]  idx_q, idx_d;
    logic [ADDR_W:0]    n_q, n_d;
    logic [ADDR_W:0]    n_raw, n_cmd;
    logic [ADDR_W-1:0]  rd_addr;
    logic [ADDR_W-1:0]  wr_addr;
    logic               we_in, we_filt;
    logic [31:0]        in_mem   [DEPTH];
    logic [31:0]        filt_mem [DEPTH];
    logic [31:0]        in_rd_q, filt_rd_q;
    logic [ACC_W-1:0]   mac_sum;
    logic [2:0]         op;
    logic               cmd_fire;
    logic               last;
    logic               unused_bits;

    assign op        = cmd_payload_function_id[2:0];
    assign rsp_valid = (state_q == RESP);
    assign cmd_ready = (state_q == IDLE) && !rsp_valid;
    assign cmd_fire  = cmd_valid && cmd_ready;
    assign wr_addr   = cmd_payload_inputs_0[ADDR_W-1:0];
    assign n_raw     = cmd_payload_inputs_0[ADDR_W:0];
    assign n_cmd     = (n_raw > (ADDR_W+1)'(DEPTH)) ? (ADDR_W+1)'(DEPTH) : n_raw;
    assign last      = ({1'b0, idx_q} == n_q - 1'b1);

    assign rsp_payload_outputs_0 = rsp_q;

    assign unused_bits = ^{cmd_payload_function_id[9:3],
                           cmd_payload_inputs_0[31:16]};

    // Simple dual-port buffers: write from cmd, sync read for the stream
    always_ff @(posedge clk) begin
        if (we_in) in_mem[wr_addr] <= cmd_payload_inputs_1;
        in_rd_q <= in_mem[rd_addr];
    end

    always_ff @(posedge clk) begin
        if (we_filt) filt_mem[wr_addr] <= cmd_payload_inputs_1;
        filt_rd_q <= filt_mem[rd_addr];
    end

    simd4_mac u_mac (
        .in_word   (in_rd_q),
        .filt_word (filt_rd_q),
        .offset    (off_q),
        .sum       (mac_sum)
    );

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        rsp_d   = rsp_q;
        off_d   = off_q;
        idx_d   = idx_q;
        n_d     = n_q;
        rd_addr = '0;
        we_in   = 1'b0;
        we_filt = 1'b0;
        case (state_q)
            IDLE: begin
                if (cmd_fire) begin
                    state_d = RESP;
                    case (op)
                        OP_WR_IN: begin
                            we_in = 1'b1;
                            rsp_d = '0;
                        end
                        OP_WR_FILT: begin
                            we_filt = 1'b1;
                            rsp_d   = '0;
                        end
                        OP_SET_OFF: begin
                            off_d = cmd_payload_inputs_0[15:0];
                            acc_d = '0;
                            rsp_d = '0;
                        end
                        OP_RUN, OP_RUN_CONT: begin
                            if (op == OP_RUN) acc_d = '0;
                            if (n_cmd == '0) begin
                                rsp_d = acc_d;
                            end else begin
                                n_d     = n_cmd;
                                state_d = FILL;
                            end
                        end
                        default: rsp_d = acc_q;
                    endcase
                end
            end
            FILL: begin
                rd_addr = '0;
                idx_d   = '0;
                state_d = STREAM;
            end
            STREAM: begin
                // read data for word idx_q is valid this cycle
                acc_d = acc_q + mac_sum;
                if (last) begin
                    rsp_d   = acc_d;
                    state_d = RESP;
                end else begin
                    rd_addr = idx_q + 1'b1;
                    idx_d   = idx_q + 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            acc_q   <= '0;
            rsp_q   <= '0;
            off_q   <= '0;
            idx_q   <= '0;
            n_q     <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            rsp_q   <= rsp_d;
            off_q   <= off_d;
            idx_q   <= idx_d;
            n_q     <= n_d;
        end
    end

endmodule

// File: tb/tb_cfu_mac_sequencer.sv
// Scoreboard bench for cfu_mac_sequencer with a dot-product reference model.
// Directed scenarios followed by randomized command streams.
module tb_cfu_mac_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [9:0]  fid = '0;
    logic [31:0] in0 = '0;
    logic [31:0] in1 = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_data;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    bit hold_lo = 1'b0;

    typedef struct {
        logic [31:0] val;
        int          cyc;
    } exp_t;
    exp_t sb[$];

    logic [31:0] min_m [64];
    logic [31:0] mf_m  [64];
    int          moff = 0;
    logic [31:0] macc = '0;

    cfu_mac_sequencer dut (
        .clk                     (clk),
        .reset                   (reset),
        .cmd_valid               (cmd_valid),
        .cmd_ready               (cmd_ready),
        .cmd_payload_function_id (fid),
        .cmd_payload_inputs_0    (in0),
        .cmd_payload_inputs_1    (in1),
        .rsp_valid               (rsp_valid),
        .rsp_ready               (rsp_ready),
        .rsp_payload_outputs_0   (rsp_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        rsp_ready = hold_lo ? 1'b0 : ($urandom_range(0, 3) != 0);
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    function automatic int dot(input logic [31:0] a, input logic [31:0] f);
        int s = 0;
        logic [7:0] ab, fb;
        for (int i = 0; i < 4; i++) begin
            ab = a[8*i +: 8];
            fb = f[8*i +: 8];
            s += (int'($signed(ab)) + moff) * int'($signed(fb));
        end
        return s;
    endfunction

    task automatic issue(input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b);
        int guard = 0;
        int n;
        int lat = 0;
        logic [31:0] ev;
        logic [15:0] t;
        exp_t e;
        @(negedge clk);
        while (!cmd_ready && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 500) begin
            total++;
            bad++;
            $display("FAIL cmd_timeout: cmd_ready low 500 cycles");
            return;
        end
        cmd_valid = 1'b1;
        fid = {$urandom_range(0, 127), op};
        in0 = a;
        in1 = b;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        case (op)
            3'd0: begin
                min_m[a[5:0]] = b;
                ev = 0;
            end
            3'd1: begin
                mf_m[a[5:0]] = b;
                ev = 0;
            end
            3'd2: begin
                t = a[15:0];
                moff = int'($signed(t));
                macc = 0;
                ev = 0;
            end
            3'd3, 3'd4: begin
                n = int'(a[6:0]);
                if (n > 64) n = 64;
                if (op == 3'd3) macc = 0;
                for (int k = 0; k < n; k++) macc = macc + dot(min_m[k], mf_m[k]);
                ev = macc;
                lat = (n > 0) ? n + 1 : 0;
            end
            default: ev = macc;
        endcase
        e.val = ev;
        e.cyc = cyc + lat;
        sb.push_back(e);
    endtask

    // Monitor: checks latency, stability and data of every response
    initial begin
        logic        pv = 1'b0;
        logic [31:0] pd = '0;
        exp_t        e;
        forever begin
            @(negedge clk);
            if (reset) begin
                pv = 1'b0;
                continue;
            end
            if (rsp_valid) begin
                if (!pv) begin
                    if (sb.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_rsp: data %0h", rsp_data);
                    end else begin
                        chk("latency", cyc, sb[0].cyc);
                    end
                end else begin
                    chk("rsp_stable", rsp_data, pd);
                end
                if (rsp_ready && sb.size() > 0) begin
                    e = sb.pop_front();
                    chk("rsp_data", rsp_data, e.val);
                end
            end
            pv = rsp_valid && !rsp_ready;
            pd = rsp_data;
        end
    end

    initial begin
        repeat (60000) @(posedge clk);
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;
        bit ok;
        logic [2:0] op;
        logic [31:0] a;

        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("reset_cmd_ready", {31'b0, cmd_ready}, 32'd1);
        chk("reset_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("reset_rsp_data", rsp_data, 32'd0);

        // Offset plus single-word run
        issue(3'd2, 32'd128, 0);
        issue(3'd0, 32'd0, 32'h01020304);
        issue(3'd1, 32'd0, 32'h01010101);
        issue(3'd3, 32'd1, 0);

        // Full buffers, extreme values, clamp
        issue(3'd2, 32'd0, 0);
        for (int i = 0; i < 64; i++) begin
            issue(3'd0, i, 32'h7F7F7F7F);
            issue(3'd1, i, 32'h80808080);
        end
        issue(3'd3, 32'd64, 0);
        issue(3'd3, 32'd70, 0);

        // Random buffer contents, then run/cont/read/set_off
        for (int i = 0; i < 64; i++) begin
            issue(3'd0, i, $urandom);
            issue(3'd1, i, $urandom);
        end
        issue(3'd2, 32'hFFFF_FFF3, 0);
        issue(3'd3, 32'd2, 0);
        issue(3'd4, 32'd2, 0);
        issue(3'd5, $urandom, 0);
        issue(3'd2, 32'd7, 0);
        issue(3'd7, 0, 0);

        // Backpressure: response held, commands refused
        hold_lo = 1'b1;
        issue(3'd3, 32'd2, 0);
        guard = 0;
        while (!rsp_valid && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        chk("hold_rsp_seen", {31'b0, rsp_valid}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            cmd_valid = 1'b1;
            fid = 10'd0;
            in0 = 32'd0;
            in1 = 32'hDEADBEEF;
            @(negedge clk);
            chk("hold_cmd_ready", {31'b0, cmd_ready}, 32'd0);
            chk("hold_rsp_valid", {31'b0, rsp_valid}, 32'd1);
        end
        cmd_valid = 1'b0;
        hold_lo = 1'b0;
        issue(3'd3, 32'd1, 0);

        // Address wrap and zero-length run
        issue(3'd0, 32'd65, 32'h11223344);
        issue(3'd3, 32'd2, 0);
        issue(3'd4, 32'd0, 0);
        issue(3'd3, 32'd0, 0);

        // Reset in the middle of a long stream
        guard = 0;
        while (sb.size() != 0 && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        issue(3'd2, 32'd5, 0);
        issue(3'd3, 32'd3, 0);
        guard = 0;
        @(negedge clk);
        while (!cmd_ready && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        cmd_valid = 1'b1;
        fid = 10'd3;
        in0 = 32'd64;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        repeat (20) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        macc = '0;
        moff = 0;
        ok = 1'b1;
        for (int i = 0; i < 70; i++) begin
            @(negedge clk);
            if (rsp_valid || !cmd_ready) ok = 1'b0;
        end
        chk("abort_quiet", {31'b0, ok}, 32'd1);
        issue(3'd5, 0, 0);
        issue(3'd3, 32'd4, 0);

        // Randomized command stream
        for (int i = 0; i < 160; i++) begin
            op = 3'($urandom_range(0, 7));
            a = $urandom;
            if (op == 3'd3 || op == 3'd4) a[6:0] = 7'($urandom_range(0, 72));
            issue(op, a, $urandom);
        end

        guard = 0;
        while (sb.size() != 0 && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: %0d responses missing", sb.size());
        end
        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
